// File: rtl/uart_record_playback_pkg.sv
// Shared types for the UART record/playback controller.
package uart_rp_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY_RD,
    S_PLAY_TX
  } state_e;

endpackage

// File: rtl/uart_record_playback_if.sv
// rx/tx valid-ready streams between the UART and the record/playback controller.
interface uart_rp_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // master = UART side, slave = controller side
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_record_playback_ram.sv
// Simple dual-port buffer: one synchronous write port, one registered read port.
module byte_buffer_ram #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register only loads on request so the word holds through tx stalls
  always_ff @(posedge clock) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_record_playback.sv
// Record/playback controller: records rx bytes, replays them on tx, or bypasses rx->tx when idle.
module uart_record_playback
  import uart_rp_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rec_pulse,
  input  logic              play_pulse,
  input  logic              loop_en,
  uart_rp_if.slave          strm,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  // One extra bit so playback of a completely full buffer still reaches count
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] rd_word;
  logic              rx_ready_o, tx_valid_o;
  logic [DATA_W-1:0] tx_data_o;
  logic              rx_fire, tx_fire, full;

  assign rx_fire = strm.rx_valid && rx_ready_o;
  assign tx_fire = tx_valid_o && strm.tx_ready;
  assign full    = (count_q == DEPTH_CNT);
  assign mem_re  = (state_q == S_PLAY_RD);

  byte_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (mem_we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (strm.rx_data),
    .rd_en_i   (mem_re),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_word)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    abort_d    = abort_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (rec_pulse && !play_pulse) begin
          state_d    = S_RECORD;
          count_d    = '0;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (play_pulse && !rec_pulse) begin
          state_d  = S_PLAY_RD;
          rd_ptr_d = '0;
        end
      end
      S_RECORD: begin
        if (rx_fire) begin
          if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (rec_pulse) begin
          state_d = S_IDLE;
        end else if (play_pulse) begin
          state_d  = S_PLAY_RD;
          rd_ptr_d = '0;
          abort_d  = 1'b0;
        end
      end
      S_PLAY_RD: begin
        if (play_pulse) begin
          abort_d = 1'b1;
        end
        if (rd_ptr_q == count_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PLAY_TX;
        end
      end
      S_PLAY_TX: begin
        if (play_pulse) begin
          abort_d = 1'b1;
        end
        if (tx_fire) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (abort_q || play_pulse) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_PLAY_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = rd_word;
    case (state_q)
      S_IDLE: begin
        if (loop_en) begin
          tx_data_o  = strm.rx_data;
          tx_valid_o = strm.rx_valid;
          rx_ready_o = strm.tx_ready;
        end
      end
      S_RECORD:  rx_ready_o = 1'b1;
      S_PLAY_TX: tx_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign strm.rx_ready = rx_ready_o;
  assign strm.tx_valid = tx_valid_o;
  assign strm.tx_data  = tx_data_o;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_uart_record_playback.sv
// Directed + randomized bench for uart_record_playback against a queue-based recording model.
module tb_uart_record_playback;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef logic [7:0] u8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            rec_pulse = 1'b0;
  logic            play_pulse = 1'b0;
  logic            loop_en = 1'b0;
  logic [ADDR_W:0] count;
  logic            overflow, busy, done;

  uart_rp_if #(.DATA_W(DATA_W)) strm ();

  uart_record_playback #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rec_pulse  (rec_pulse),
    .play_pulse (play_pulse),
    .loop_en    (loop_en),
    .strm       (strm),
    .count      (count),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  u8  model_q[$];
  bit model_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_rec();
    rec_pulse = 1'b1;
    tick();
    rec_pulse = 1'b0;
  endtask

  task automatic pulse_play();
    play_pulse = 1'b1;
    tick();
    play_pulse = 1'b0;
  endtask

  // Recording rule: keep the first DEPTH bytes, flag any byte beyond that
  task automatic model_rx(input u8 b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic record_bytes(input string tag, input u8 data[$], input int gap_max);
    pulse_rec();
    model_q.delete();
    model_ovf = 1'b0;
    chk({tag, "_rec_busy"}, busy, 1);
    foreach (data[i]) begin
      strm.rx_valid = 1'b0;
      repeat ($urandom_range(gap_max)) tick();
      strm.rx_valid = 1'b1;
      strm.rx_data  = data[i];
      #1;
      chk({tag, "_rx_ready"}, strm.rx_ready, 1);
      tick();
      model_rx(data[i]);
      $display("rx byte %02h stored_model=%0d", data[i], model_q.size());
    end
    strm.rx_valid = 1'b0;
    pulse_rec();
    chk({tag, "_rec_idle"}, busy, 0);
    chk({tag, "_count"}, count, model_q.size());
    chk({tag, "_overflow"}, overflow, model_ovf);
  endtask

  task automatic play_and_check(input string tag, input int stall_pct);
    u8    got[$];
    int   cyc;
    logic prev_stall;
    u8    prev_data;
    got.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    cyc        = 0;
    strm.tx_ready = 1'b0;
    pulse_play();
    chk({tag, "_rd_no_valid"}, strm.tx_valid, 0);
    chk({tag, "_rd_busy"}, busy, 1);
    tick();
    chk({tag, "_first_valid"}, strm.tx_valid, model_q.size() != 0);
    chk({tag, "_empty_done"}, done, model_q.size() == 0);
    while (cyc < 200) begin
      if (done) break;
      strm.tx_ready = ($urandom_range(99) >= stall_pct);
      if (strm.tx_valid) begin
        if (prev_stall) chk({tag, "_stall_stable"}, strm.tx_data, prev_data);
        if (strm.tx_ready) begin
          got.push_back(strm.tx_data);
          $display("tx byte %02h index=%0d", strm.tx_data, got.size() - 1);
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_data  = strm.tx_data;
        end
      end
      tick();
      cyc++;
    end
    strm.tx_ready = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_end_idle"}, busy, 0);
    chk({tag, "_len"}, got.size(), model_q.size());
    for (int i = 0; i < got.size() && i < model_q.size(); i++) begin
      chk({tag, "_byte"}, got[i], model_q[i]);
    end
    chk({tag, "_count_kept"}, count, model_q.size());
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    u8 seq[$];
    u8 held;
    strm.rx_data  = '0;
    strm.rx_valid = 1'b0;
    strm.tx_ready = 1'b0;

    // Reset state
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_valid", strm.tx_valid, 0);
    chk("rst_rx_ready", strm.rx_ready, 0);

    // Basic record and play
    seq = '{8'h30, 8'h31, 8'h32};
    record_bytes("t1", seq, 0);
    play_and_check("t1", 0);

    // Overflow at DEPTH
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    record_bytes("t2", seq, 1);
    chk("t2_ovf_model", overflow, 1);
    play_and_check("t2", 0);
    play_and_check("t2_replay", 40);

    // Empty playback
    seq.delete();
    record_bytes("t3", seq, 0);
    play_and_check("t3", 0);

    // Stall then abort while stalled
    seq = '{8'h11, 8'h22, 8'h33};
    record_bytes("t4", seq, 0);
    strm.tx_ready = 1'b0;
    pulse_play();
    tick();
    held = model_q[0];
    for (int k = 0; k < 10; k++) begin
      play_pulse = (k == 3);
      chk("t4_stall_valid", strm.tx_valid, 1);
      chk("t4_stall_data", strm.tx_data, held);
      tick();
    end
    play_pulse = 1'b0;
    strm.tx_ready = 1'b1;
    tick();
    strm.tx_ready = 1'b0;
    chk("t4_abort_done", done, 1);
    chk("t4_abort_idle", busy, 0);
    chk("t4_abort_txv", strm.tx_valid, 0);

    // Loopback only in IDLE
    loop_en = 1'b1;
    strm.rx_valid = 1'b1;
    strm.rx_data  = 8'hA5;
    strm.tx_ready = 1'b1;
    #1;
    chk("t5_loop_valid", strm.tx_valid, 1);
    chk("t5_loop_data", strm.tx_data, 8'hA5);
    chk("t5_loop_ready", strm.rx_ready, 1);
    strm.tx_ready = 1'b0;
    #1;
    chk("t5_loop_bp", strm.rx_ready, 0);
    strm.rx_valid = 1'b0;
    pulse_rec();
    model_q.delete();
    model_ovf = 1'b0;
    strm.rx_valid = 1'b1;
    strm.rx_data  = 8'h5A;
    strm.tx_ready = 1'b1;
    #1;
    chk("t5_rec_no_bypass", strm.tx_valid, 0);
    chk("t5_rec_ready", strm.rx_ready, 1);
    tick();
    model_rx(8'h5A);
    strm.rx_valid = 1'b0;
    strm.tx_ready = 1'b0;
    pulse_rec();
    loop_en = 1'b0;
    chk("t5_count", count, model_q.size());
    play_and_check("t5", 0);

    // Reset mid-playback, then simultaneous pulses
    seq = '{8'hC0, 8'hC1, 8'hC2};
    record_bytes("t6", seq, 0);
    strm.tx_ready = 1'b1;
    pulse_play();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    strm.tx_ready = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    chk("t6_rst_txv", strm.tx_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_busy", busy, 0);
    rec_pulse  = 1'b1;
    play_pulse = 1'b1;
    tick();
    rec_pulse  = 1'b0;
    play_pulse = 1'b0;
    chk("t6_both_idle", busy, 0);
    tick();
    chk("t6_both_idle2", busy, 0);

    // Randomized record/play rounds
    for (int r = 0; r < 8; r++) begin
      seq.delete();
      repeat ($urandom_range(7)) seq.push_back(u8'($urandom));
      record_bytes("rnd", seq, 2);
      play_and_check("rnd", 30);
      play_and_check("rnd_replay", 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
